// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory request/response bus between the MEM stage and data memory
interface mem_access_stage_if #(
  parameter int size = 32
);
  logic            req;
  logic            we;
  logic [size-1:0] addr;
  logic [3:0]      be;
  logic [size-1:0] wdata;
  logic            ack;
  logic [size-1:0] rdata;
  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM register, data-memory access FSM and MEM/WB register; DMEM_TIMEOUT_EN bounds the ack wait
module mem_access_stage #(
  parameter int size    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic [size-1:0]    FU_i,
  input  logic [size-1:0]    RAM_DATA_i,
  input  logic [size-1:0]    PCplus_i,
  input  logic [11:0]        Control_Signal_i,
  output logic               stall_o,
  mem_access_stage_if.master dmem,
  output logic [size-1:0]    Data_MEM_o,
  output logic [size-1:0]    WB_data_o,
  output logic [4:0]         WB_rd_o,
  output logic               WB_we_o,
  output logic               misaligned_o,
  output logic               bus_err_o
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t          r_state, w_next;
  logic            r_valid;
  logic [size-1:0] r_fu, r_sd, r_pc;
  logic [11:0]     r_ctl;
  logic [1:0]      w_off, w_sz;
  logic            w_memop, w_go, w_to;
  logic [15:0]     w_lane;
  logic [size-1:0] w_load;

  assign w_off        = r_fu[1:0];
  assign w_sz         = r_ctl[2:1];
  assign w_memop      = r_valid & (r_ctl[5] | r_ctl[4]);
  assign misaligned_o = w_memop & (((w_sz == 2'b01) & w_off[0]) | ((w_sz == 2'b10) & (|w_off)));
  assign w_go         = w_memop & ~misaligned_o;
  assign Data_MEM_o   = r_ctl[0] ? r_pc : r_fu;

  assign dmem.req   = (r_state == WAIT) | w_go;
  assign dmem.we    = r_ctl[5];
  assign dmem.addr  = {r_fu[size-1:2], 2'b00};
  assign dmem.be    = (w_sz == 2'b00) ? 4'b0001 << w_off : (w_sz == 2'b01) ? 4'b0011 << w_off : 4'b1111;
  assign dmem.wdata = (w_sz == 2'b00) ? {4{r_sd[7:0]}} : (w_sz == 2'b01) ? {2{r_sd[15:0]}} : r_sd;

  assign w_lane = 16'(dmem.rdata >> {w_off, 3'b000});
  assign w_load = w_to ? '0 :
                  (w_sz == 2'b00) ? {{24{w_lane[7] & ~r_ctl[3]}}, w_lane[7:0]} :
                  (w_sz == 2'b01) ? {{16{w_lane[15] & ~r_ctl[3]}}, w_lane[15:0]} : dmem.rdata;

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  assign w_to = (r_state == WAIT) & ~dmem.ack & (r_cnt == CW'(TIMEOUT));
  // count stall cycles of the access in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else r_cnt <= (w_next == WAIT) ? r_cnt + 1'b1 : '0;
`else
  assign w_to = 1'b0;
`endif
  assign bus_err_o = w_to;

  // stall while a request is outstanding; the ack (or timeout) cycle completes it
  always_comb begin
    stall_o = (r_state == WAIT) ? ~(dmem.ack | w_to) : w_go & ~dmem.ack;
    w_next  = stall_o ? WAIT : IDLE;
  end

  // access FSM state
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;

  // EX/MEM register, frozen while the access is pending
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_valid <= 1'b0;
      r_fu    <= '0;
      r_sd    <= '0;
      r_pc    <= '0;
      r_ctl   <= '0;
    end else if (!stall_o) begin
      r_valid <= valid_i;
      r_fu    <= FU_i;
      r_sd    <= RAM_DATA_i;
      r_pc    <= PCplus_i;
      r_ctl   <= Control_Signal_i;
    end

  // MEM/WB register, takes a bubble while stalled or for dropped/failed accesses
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      WB_data_o <= '0;
      WB_rd_o   <= '0;
      WB_we_o   <= 1'b0;
    end else begin
      WB_data_o <= r_ctl[4] ? w_load : Data_MEM_o;
      WB_rd_o   <= r_ctl[11:7];
      WB_we_o   <= ~stall_o & r_valid & r_ctl[6] & ~misaligned_o & ~w_to & (|r_ctl[11:7]);
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized bench for mem_access_stage against a transaction-level model
module tb_mem_access_stage;
  typedef struct packed {
    logic        v;
    logic [31:0] fu, sd, pc;
    logic [4:0]  rd;
    logic        rwe, mwe, mre;
    logic [2:0]  f3;
    logic        ws;
  } instr_t;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_stage_if #(.size(32)) dm();
  instr_t      ex;
  logic        stall_o, WB_we_o, misaligned_o, bus_err_o;
  logic [31:0] Data_MEM_o, WB_data_o;
  logic [4:0]  WB_rd_o;

  mem_access_stage #(.size(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .valid_i(ex.v), .FU_i(ex.fu), .RAM_DATA_i(ex.sd), .PCplus_i(ex.pc),
    .Control_Signal_i({ex.rd, ex.rwe, ex.mwe, ex.mre, ex.f3, ex.ws}),
    .stall_o(stall_o), .dmem(dm), .Data_MEM_o(Data_MEM_o), .WB_data_o(WB_data_o),
    .WB_rd_o(WB_rd_o), .WB_we_o(WB_we_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  int checks = 0, errors = 0;
  logic [31:0] mem [64];
  logic [31:0] gold [64];
  instr_t in_mem;
  logic wb_we;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  int wcnt, rcnt, fixed_wait, stall_seen, err_seen;
  logic busy, stray;
  logic last_req, last_stall, last_mis;
  logic [3:0] last_be;
  logic [31:0] last_addr, last_wdata;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic instr_t mk(logic [31:0] fu, logic [31:0] sd, logic [4:0] rd, logic rwe, logic mwe, logic mre, logic [2:0] f3);
    instr_t t;
    t = '{v: 1'b1, fu: fu, sd: sd, pc: fu + 32'h1000, rd: rd, rwe: rwe, mwe: mwe, mre: mre, f3: f3, ws: 1'b0};
    return t;
  endfunction

  function automatic instr_t rnd();
    instr_t t;
    logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int k = $urandom_range(0, 9);
    t.v = (k != 0); t.fu = {24'h0, 8'($urandom)}; t.sd = $urandom; t.pc = $urandom;
    t.rd = 5'($urandom); t.ws = 1'($urandom); t.f3 = 3'($urandom);
    t.rwe = 1'b1; t.mwe = 1'b0; t.mre = 1'b0;
    if (k == 0) begin t.mwe = 1'($urandom); t.mre = 1'($urandom); end
    else if (k <= 4) begin t.mre = 1'b1; t.ws = 1'b0; t.f3 = lf[$urandom_range(0, 4)]; end
    else if (k <= 6) begin t.mwe = 1'b1; t.rwe = 1'b0; t.f3 = 3'($urandom_range(0, 2)); end
    return t;
  endfunction

  function automatic logic misal(instr_t m);
    int n = 1 << m.f3[1:0];
    return (int'(m.fu[7:0]) % n) != 0;
  endfunction

  function automatic logic [31:0] load_val(instr_t m);
    logic [31:0] w = gold[m.fu[7:2]] >> (8 * m.fu[1:0]);
    case (m.f3)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd4:    return {24'h0, w[7:0]};
      3'd5:    return {16'h0, w[15:0]};
      default: return gold[m.fu[7:2]];
    endcase
  endfunction

  function automatic void gold_store(instr_t m);
    int off = int'(m.fu[1:0]);
    int n = 1 << m.f3[1:0];
    logic [31:0] w = gold[m.fu[7:2]];
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + n) w[8*i +: 8] = m.sd[8*(i-off) +: 8];
    gold[m.fu[7:2]] = w;
  endfunction

  task automatic respond();
    if (dm.req) begin
      if (!busy) begin
        busy = 1'b1;
        rcnt = (fixed_wait == -2) ? $urandom_range(0, 3) : fixed_wait;
      end
      dm.ack = (rcnt == 0);
      dm.rdata = mem[dm.addr[7:2]];
      if (rcnt == 0) busy = 1'b0;
      else if (rcnt > 0) rcnt--;
    end else begin
      busy = 1'b0;
      dm.ack = stray & 1'($urandom);
      dm.rdata = $urandom;
    end
  endtask

  task automatic tick(output logic st);
    instr_t m = in_mem;
    logic em, mis, er, tout, nwe, wr;
    logic [31:0] nd, wd;
    logic [3:0] wbe;
    logic [5:0] wa;
    #1 respond();
    #2;
    em = m.v & (m.mwe | m.mre);
    mis = em & misal(m);
    er = em & !mis;
`ifdef DMEM_TIMEOUT_EN
    tout = er & (wcnt == TO) & !dm.ack;
`else
    tout = 1'b0;
`endif
    st = er & !dm.ack & !tout;
    chk("req", 32'(dm.req), 32'(er));
    chk("stall", 32'(stall_o), 32'(st));
    chk("misaligned", 32'(misaligned_o), 32'(mis));
    chk("bus_err", 32'(bus_err_o), 32'(tout));
    if (m.v) chk("data_mem", Data_MEM_o, m.ws ? m.pc : m.fu);
    if (er) begin
      chk("addr", dm.addr, {m.fu[31:2], 2'b00});
      chk("we", 32'(dm.we), 32'(m.mwe));
    end
    chk("wb_we", 32'(WB_we_o), 32'(wb_we));
    if (wb_we) begin
      chk("wb_rd", 32'(WB_rd_o), 32'(wb_rd));
      chk("wb_data", WB_data_o, wb_data);
    end
    last_req = dm.req; last_stall = stall_o; last_mis = misaligned_o;
    last_be = dm.be; last_addr = dm.addr; last_wdata = dm.wdata;
    if (stall_o) stall_seen++;
    if (bus_err_o) err_seen++;
    nwe = 1'b0;
    nd = wb_data;
    if (!st) begin
      nwe = m.v & m.rwe & !mis & !tout & (m.rd != 0);
      nd = m.mre ? (tout ? 32'h0 : load_val(m)) : (m.ws ? m.pc : m.fu);
      if (er & m.mwe & !tout) gold_store(m);
    end
    wcnt = st ? wcnt + 1 : 0;
    wr = dm.req & dm.ack & dm.we;
    wa = dm.addr[7:2]; wbe = dm.be; wd = dm.wdata;
    @(posedge clk);
    if (wr) for (int i = 0; i < 4; i++) if (wbe[i]) mem[wa][8*i +: 8] = wd[8*i +: 8];
    if (!st) in_mem = ex;
    wb_we = nwe; wb_rd = m.rd; wb_data = nd;
    #1;
  endtask

  task automatic issue(instr_t t);
    logic st;
    int n = 0;
    ex = t;
    do begin tick(st); n++; end while (st && n < 40);
    if (n >= 40) chk("stall_bound", 32'(st), 32'(0));
  endtask

  task automatic reset_model();
    in_mem = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0; wcnt = 0; busy = 1'b0; rcnt = 0;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req"}, 32'(dm.req), 32'(0));
    chk({tag, "_stall"}, 32'(stall_o), 32'(0));
    chk({tag, "_wb_data"}, WB_data_o, 32'h0);
    chk({tag, "_wb_rd"}, 32'(WB_rd_o), 32'(0));
    chk({tag, "_wb_we"}, 32'(WB_we_o), 32'(0));
    chk({tag, "_data_mem"}, Data_MEM_o, 32'h0);
    chk({tag, "_mis"}, 32'(misaligned_o), 32'(0));
    chk({tag, "_bus_err"}, 32'(bus_err_o), 32'(0));
  endtask

  initial begin
    instr_t bub;
    bub = '0;
    ex = bub;
    dm.ack = 1'b0; dm.rdata = '0;
    stray = 1'b0; fixed_wait = -1; stall_seen = 0; err_seen = 0;
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; gold[i] = mem[i]; end
    mem[0] = 32'h80FF_FF7F; gold[0] = 32'h80FF_FF7F;
    reset_model();
    reset = 1'b1;
    #3 chk_reset_outputs("rst");
    @(posedge clk); #1 reset = 1'b0;

    issue(mk(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0));
    issue(bub);
    chk("t1_req", 32'(last_req), 32'(0));
    chk("t1_stall", 32'(last_stall), 32'(0));
    chk("t1_wb_data", WB_data_o, 32'h1234);
    chk("t1_wb_rd", 32'(WB_rd_o), 32'(5));
    chk("t1_wb_we", 32'(WB_we_o), 32'(1));

    fixed_wait = 2;
    issue(mk(32'h103, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 3'd0));
    stall_seen = 0;
    issue(bub);
    chk("t2_stall_cycles", 32'(stall_seen), 32'(2));
    chk("t2_wb_data", WB_data_o, 32'hFFFF_FF80);
    chk("t2_wb_we", 32'(WB_we_o), 32'(1));

    fixed_wait = 0;
    issue(mk(32'h102, 32'hABCD_1234, 5'd0, 1'b0, 1'b1, 1'b0, 3'd1));
    issue(bub);
    chk("t3_be", 32'(last_be), 32'(4'b1100));
    chk("t3_wdata", last_wdata, 32'h1234_1234);
    chk("t3_addr", last_addr, 32'h100);
    chk("t3_stall", 32'(last_stall), 32'(0));

    issue(mk(32'h101, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 3'd2));
    issue(bub);
    chk("t4_req", 32'(last_req), 32'(0));
    chk("t4_mis", 32'(last_mis), 32'(1));
    chk("t4_wb_we", 32'(WB_we_o), 32'(0));

    fixed_wait = -1;
    issue(mk(32'h104, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 3'd2));
    begin
      logic st;
      ex = bub;
      tick(st); tick(st);
    end
    #1 reset = 1'b1;
    #1 chk_reset_outputs("t5");
    reset_model();
    @(posedge clk); #1 reset = 1'b0;

`ifdef DMEM_TIMEOUT_EN
    fixed_wait = -1;
    issue(mk(32'h108, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 3'd2));
    stall_seen = 0; err_seen = 0;
    issue(bub);
    chk("t6_stall_cycles", 32'(stall_seen), 32'(TO));
    chk("t6_bus_err", 32'(err_seen), 32'(1));
    chk("t6_wb_we", 32'(WB_we_o), 32'(0));
    fixed_wait = 0;
    issue(mk(32'h55, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 3'd0));
    issue(bub);
    chk("t6_next_wb", WB_data_o, 32'h55);
`endif

    fixed_wait = -2; stray = 1'b1;
    repeat (400) issue(rnd());
    repeat (3) issue(bub);
    for (int i = 0; i < 64; i++) chk("mem_word", mem[i], gold[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
